// File: rtl/comp_seq_if.sv
// rtl/comp_seq_if.sv - operand/mode request and held-result bundle for comp_seq
interface comp_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sgn;
    logic             abort;
    logic             out_valid;
    logic             gt;
    logic             lt;
    logic             eq;

    modport master (
        output in_valid, a, b, sgn, abort,
        input  in_ready, out_valid, gt, lt, eq
    );

    modport slave (
        input  in_valid, a, b, sgn, abort,
        output in_ready, out_valid, gt, lt, eq
    );
endinterface

// File: rtl/comp_seq.sv
// rtl/comp_seq.sv - iterative MSB-first magnitude comparator, DIGIT bits per cycle
// Unsigned or two's-complement per operation; result held in DONE until accept/abort/reset.
module comp_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    comp_seq_if.slave  bus
);
    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("comp_seq: DIGIT must be in 1..WIDTH and divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic             sgn_q;
    logic [IW-1:0]    idx_q;
    logic             out_valid_q;
    logic             gt_q;
    logic             lt_q;
    logic             eq_q;

    logic [DIGIT-1:0] chunk_a;
    logic [DIGIT-1:0] chunk_b;
    logic             top_chunk;
    logic             accept;

    // Signed mode flips the sign bit of the top chunk only, turning the
    // two's-complement order into a plain unsigned order chunk by chunk.
    always_comb begin
        top_chunk = (idx_q == IW'(NCHUNK - 1));
        chunk_a   = DIGIT'(ra_q >> (DIGIT * int'(idx_q)));
        chunk_b   = DIGIT'(rb_q >> (DIGIT * int'(idx_q)));
        if (sgn_q && top_chunk) begin
            chunk_a[DIGIT-1] = ~chunk_a[DIGIT-1];
            chunk_b[DIGIT-1] = ~chunk_b[DIGIT-1];
        end
    end

    assign accept       = bus.in_valid && (state_q != CMP);
    assign bus.in_ready = (state_q != CMP);
    assign bus.out_valid = out_valid_q;
    assign bus.gt        = gt_q;
    assign bus.lt        = lt_q;
    assign bus.eq        = eq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ra_q        <= '0;
            rb_q        <= '0;
            sgn_q       <= 1'b0;
            idx_q       <= IW'(NCHUNK - 1);
            out_valid_q <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ra_q    <= bus.a;
                        rb_q    <= bus.b;
                        sgn_q   <= bus.sgn;
                        idx_q   <= IW'(NCHUNK - 1);
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    // Abort takes priority over a decision in the same cycle.
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else if (chunk_a > chunk_b) begin
                        gt_q        <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (chunk_a < chunk_b) begin
                        lt_q        <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (idx_q == '0) begin
                        eq_q        <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.abort) begin
                        out_valid_q <= 1'b0;
                        gt_q        <= 1'b0;
                        lt_q        <= 1'b0;
                        eq_q        <= 1'b0;
                        state_q     <= IDLE;
                    end else if (accept) begin
                        ra_q        <= bus.a;
                        rb_q        <= bus.b;
                        sgn_q       <= bus.sgn;
                        idx_q       <= IW'(NCHUNK - 1);
                        out_valid_q <= 1'b0;
                        gt_q        <= 1'b0;
                        lt_q        <= 1'b0;
                        eq_q        <= 1'b0;
                        state_q     <= CMP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_comp_seq.sv
// tb/tb_comp_seq.sv - scoreboard bench for comp_seq, DIGIT=4 directed plus DIGIT 1/4/16 random
module tb_comp_seq;
    typedef struct {
        logic gt;
        logic lt;
        logic eq;
        int   lat;
        int   acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv4, ivr, ts, tab;
    logic [15:0] ta, tb_v;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        q4[$];
    exp_t        q1[$];
    exp_t        q16[$];
    logic        pov4 = 1'b0, pov1 = 1'b0, pov16 = 1'b0;

    comp_seq_if #(.WIDTH(16)) bus4 ();
    comp_seq_if #(.WIDTH(16)) bus1 ();
    comp_seq_if #(.WIDTH(16)) bus16 ();

    assign bus4.in_valid  = iv4;
    assign bus4.a         = ta;
    assign bus4.b         = tb_v;
    assign bus4.sgn       = ts;
    assign bus4.abort     = tab;
    assign bus1.in_valid  = ivr;
    assign bus1.a         = ta;
    assign bus1.b         = tb_v;
    assign bus1.sgn       = ts;
    assign bus1.abort     = 1'b0;
    assign bus16.in_valid = ivr;
    assign bus16.a        = ta;
    assign bus16.b        = tb_v;
    assign bus16.sgn      = ts;
    assign bus16.abort    = 1'b0;

    comp_seq #(.WIDTH(16), .DIGIT(4))  u4  (.clk(clk), .rst(rst), .bus(bus4.slave));
    comp_seq #(.WIDTH(16), .DIGIT(1))  u1  (.clk(clk), .rst(rst), .bus(bus1.slave));
    comp_seq #(.WIDTH(16), .DIGIT(16)) u16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int lane, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s lane=%0d actual=%0d required=%0d t=%0t", nm, lane, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                   input int dig, input int acc);
        exp_t e;
        int   nch;
        int   d;
        nch = 16 / dig;
        if (s) begin
            e.gt = ($signed(a) > $signed(b));
            e.lt = ($signed(a) < $signed(b));
        end else begin
            e.gt = (a > b);
            e.lt = (a < b);
        end
        e.eq  = (a == b);
        e.lat = nch;
        d     = int'(a ^ b);
        for (int c = 0; c < nch; c++)
            if (((d >> (c * dig)) & ((1 << dig) - 1)) != 0) e.lat = nch - c;
        e.acc = acc;
        return e;
    endfunction

    task automatic mon(input int lane, input logic ov, input logic gt, input logic lt,
                       input logic eq, input logic pov);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (ov && !pov) begin
            case (lane)
                4:  if (q4.size()  != 0) begin e = q4.pop_front();  have = 1'b1; end
                1:  if (q1.size()  != 0) begin e = q1.pop_front();  have = 1'b1; end
                default: if (q16.size() != 0) begin e = q16.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                chk("unexpected_result", lane, 1, 0);
            end else begin
                chk("result_gt_lt_eq", lane, int'({gt, lt, eq}), int'({e.gt, e.lt, e.eq}));
                chk("latency", lane, cyc - e.acc, e.lat);
            end
        end
        if (ov) chk("onehot", lane, int'(gt) + int'(lt) + int'(eq), 1);
        else    chk("idle_flags_zero", lane, int'({gt, lt, eq}), 0);
    endtask

    always @(negedge clk) begin
        mon(4, bus4.out_valid, bus4.gt, bus4.lt, bus4.eq, pov4);
        pov4 = bus4.out_valid;
    end
    always @(negedge clk) begin
        mon(1, bus1.out_valid, bus1.gt, bus1.lt, bus1.eq, pov1);
        pov1 = bus1.out_valid;
    end
    always @(negedge clk) begin
        mon(16, bus16.out_valid, bus16.gt, bus16.lt, bus16.eq, pov16);
        pov16 = bus16.out_valid;
    end

    task automatic drain();
        int i;
        i = 0;
        while ((q4.size() + q1.size() + q16.size()) != 0 && i < 64) begin
            @(negedge clk);
            i++;
        end
        chk("drain_timeout", 0, q4.size() + q1.size() + q16.size(), 0);
        q4.delete();
        q1.delete();
        q16.delete();
    endtask

    // r = {gt, lt, eq}; ab drives abort alongside the accept (no effect when not in CMP/DONE-abort)
    task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [2:0] r, input int n, input bit ab);
        exp_t e;
        @(negedge clk);
        ta = a; tb_v = b; ts = s; iv4 = 1'b1; tab = ab;
        e.gt = r[2]; e.lt = r[1]; e.eq = r[0]; e.lat = n; e.acc = cyc + 1;
        q4.push_back(e);
        @(negedge clk);
        iv4 = 1'b0; tab = 1'b0; ta = ~a; tb_v = a;
        drain();
    endtask

    task automatic quiet4(input string nm, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            chk(nm, 4, int'(bus4.out_valid), 0);
        end
    endtask

    initial begin
        exp_t e;
        int   w;
        rst = 1'b1; iv4 = 1'b0; ivr = 1'b0; ts = 1'b0; tab = 1'b0; ta = '0; tb_v = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 4, int'(bus4.out_valid), 0);
        chk("rst_flags", 4, int'({bus4.gt, bus4.lt, bus4.eq}), 0);
        chk("rst_in_ready", 4, int'(bus4.in_ready), 1);
        iv4 = 1'b1;
        @(negedge clk);
        chk("rst_ignores_valid", 4, int'(bus4.in_ready), 1);
        iv4 = 1'b0; rst = 1'b0;

        // asynchronous reset in the middle of a compare
        @(negedge clk);
        ta = 16'h1234; tb_v = 16'h1234; ts = 1'b0; iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        @(negedge clk);
        chk("cmp_busy", 4, int'(bus4.in_ready), 0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 4, int'(bus4.out_valid), 0);
        chk("midrst_flags", 4, int'({bus4.gt, bus4.lt, bus4.eq}), 0);
        chk("midrst_in_ready", 4, int'(bus4.in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        op4(16'h0001, 16'h0002, 1'b0, 3'b010, 4, 1'b0);

        op4(16'h1234, 16'h1234, 1'b0, 3'b001, 4, 1'b0);
        op4(16'h1235, 16'h1234, 1'b0, 3'b100, 4, 1'b0);
        op4(16'h8000, 16'h7FFF, 1'b0, 3'b100, 1, 1'b0);
        op4(16'h8000, 16'h7FFF, 1'b1, 3'b010, 1, 1'b0);
        op4(16'hFFFF, 16'hFFFE, 1'b1, 3'b100, 4, 1'b0);
        op4(16'h00A0, 16'h00B0, 1'b1, 3'b010, 3, 1'b0);
        op4(16'hF000, 16'h1000, 1'b1, 3'b010, 1, 1'b0);
        op4(16'hF000, 16'h1000, 1'b0, 3'b100, 1, 1'b0);

        // abort in the first CMP cycle
        @(negedge clk);
        ta = 16'h0F00; tb_v = 16'h0E00; ts = 1'b0; iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0; tab = 1'b1;
        @(negedge clk);
        tab = 1'b0;
        chk("abort_cmp_ready", 4, int'(bus4.in_ready), 1);
        quiet4("abort_cmp_no_result", 5);

        // abort in the cycle that would have decided (second chunk differs)
        @(negedge clk);
        ta = 16'h0F00; tb_v = 16'h0E00; iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        @(negedge clk);
        tab = 1'b1;
        @(negedge clk);
        tab = 1'b0;
        chk("abort_decide_ready", 4, int'(bus4.in_ready), 1);
        quiet4("abort_decide_no_result", 4);

        // abort while IDLE does not block an accept
        op4(16'h0F00, 16'h0E00, 1'b0, 3'b100, 2, 1'b1);

        // abort in DONE wins over a same-cycle accept
        @(negedge clk);
        tab = 1'b1; iv4 = 1'b1; ta = 16'h0001; tb_v = 16'h0002;
        @(negedge clk);
        tab = 1'b0; iv4 = 1'b0;
        chk("abort_done_out_valid", 4, int'(bus4.out_valid), 0);
        chk("abort_done_flags", 4, int'({bus4.gt, bus4.lt, bus4.eq}), 0);
        chk("abort_done_ready", 4, int'(bus4.in_ready), 1);
        quiet4("abort_done_no_result", 6);

        // back-to-back: in_valid held from DONE through the following CMP cycles
        @(negedge clk);
        ta = 16'h8000; tb_v = 16'h7FFF; ts = 1'b0; iv4 = 1'b1;
        e.gt = 1'b1; e.lt = 1'b0; e.eq = 1'b0; e.lat = 1; e.acc = cyc + 1;
        q4.push_back(e);
        @(negedge clk);
        iv4 = 1'b0;
        w = 0;
        while (!bus4.out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("b2b_first_timeout", 4, int'(bus4.out_valid), 1);
        ta = 16'h1234; tb_v = 16'h1234; iv4 = 1'b1;
        e.gt = 1'b0; e.lt = 1'b0; e.eq = 1'b1; e.lat = 4; e.acc = cyc + 1;
        q4.push_back(e);
        @(negedge clk);
        chk("b2b_drop", 4, int'(bus4.out_valid), 0);
        ta = 16'hFFFF; tb_v = 16'h0000;
        repeat (4) @(negedge clk);
        iv4 = 1'b0;
        drain();

        // random pairs, all three digit widths in lockstep
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] ra, rb;
            logic        rs;
            int          k;
            ra = 16'($urandom);
            k  = $urandom_range(3, 0);
            case (k)
                0:       rb = 16'($urandom);
                1:       rb = ra;
                2:       rb = ra ^ (16'h0001 << $urandom_range(15, 0));
                default: rb = {ra[15:8], 8'($urandom)};
            endcase
            rs = 1'($urandom_range(1, 0));
            @(negedge clk);
            ta = ra; tb_v = rb; ts = rs; iv4 = 1'b1; ivr = 1'b1;
            q4.push_back(model(ra, rb, rs, 4, cyc + 1));
            q1.push_back(model(ra, rb, rs, 1, cyc + 1));
            q16.push_back(model(ra, rb, rs, 16, cyc + 1));
            @(negedge clk);
            iv4 = 1'b0; ivr = 1'b0;
            drain();
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
